// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
package rr_arb_pkg;
  localparam int N_REQ = 4;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/rr_arbiter4_pick.sv
// Combinational round-robin pick: first set req bit scanning ptr, ptr+1, ... mod 4.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] sel_onehot,
  output logic [1:0] sel_idx
);
  logic       found;
  logic [1:0] cand;

  always_comb begin
    found      = 1'b0;
    sel_idx    = 2'd0;
    cand       = 2'd0;
    sel_onehot = 4'b0000;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
    // All-zero select when nothing requests, so gnt can never be loaded multi-hot.
    if (found) sel_onehot = idx_to_onehot(sel_idx);
  end
endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and hold-timeout watchdog.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);
  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  logic [3:0] sel_onehot;
  logic [1:0] sel_idx;
  logic       req_held, hold_lim, release_now;

  rr_pick4 u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx)
  );

  assign req_held    = req[idx_q];
  assign hold_lim    = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
  assign release_now = ack || !req_held || hold_lim;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (req != 4'b0000) begin
          state_d    = GRANT;
          gnt_d      = sel_onehot;
          idx_d      = sel_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          ptr_d     = idx_q + 2'd1;
          // Flag only releases forced purely by the hold limit.
          timeout_d = !ack && req_held;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      idx_q      <= 2'd0;
      gnt_q      <= 4'b0000;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      gnt_q      <= gnt_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == GRANT);
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed table-driven bench for rr_arbiter4 (HOLD_MAX=4).
module tb_rr_arbiter4;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter4 #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic       vld;
    logic       tmo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] q, logic a, logic [3:0] g, logic v, logic t);
    vec_t x;
    x.rst = r; x.req = q; x.ack = a; x.gnt = g; x.vld = v; x.tmo = t;
    return x;
  endfunction

  task automatic check(string name, logic [3:0] eg, logic ev, logic et);
    total++;
    if (gnt !== eg || gnt_valid !== ev || timeout !== et) begin
      bad++;
      $display("FAIL %s: got gnt=%b vld=%b tmo=%b, want gnt=%b vld=%b tmo=%b",
               name, gnt, gnt_valid, timeout, eg, ev, et);
    end
    total++;
    if (!$onehot0(gnt) || (gnt_valid !== (gnt != 4'b0000))) begin
      bad++;
      $display("FAIL %s invariant: gnt=%b vld=%b", name, gnt, gnt_valid);
    end
  endtask

  task automatic step(string name, logic r, logic [3:0] q, logic a,
                      logic [3:0] eg, logic ev, logic et);
    rst = r; req = q; ack = a;
    @(posedge clk);
    #1;
    check(name, eg, ev, et);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; ack = 1'b0;

    // Reset, idle (ack in IDLE ignored), single request released by ack -> ptr=3
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 1, 4'b0000, 0, 0));
    // ptr=3: req 1001 picks 3, then wrap gives 0
    tbl.push_back(mk(0, 4'b1001, 0, 4'b1000, 1, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1001, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 4'b0000, 0, 0));
    // ptr=1: timeout on held req 0010 after exactly 4 grant cycles
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 0));
    // req drop with ack: single release, no timeout; ptr=2
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0));
    // ptr=2: pick 0; req drops exactly at hold limit -> no timeout
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0));
    // ptr=1: grant 2, non-granted req changes ignored, reset mid-grant
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(1, 4'b0100, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 1, 0));
    // ack coinciding with the hold limit -> no timeout
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0));

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req, tbl[i].ack,
           tbl[i].gnt, tbl[i].vld, tbl[i].tmo);
    end

    // Fairness after reset: 0,1,2,3,0 with an idle gap after each ack
    step("rr_rst", 1, 4'b1111, 0, 4'b0000, 0, 0);
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_oh;
      exp_oh = 4'b0001 << (k % 4);
      step($sformatf("rr_gnt%0d", k), 0, 4'b1111, 0, exp_oh, 1, 0);
      step($sformatf("rr_gap%0d", k), 0, 4'b1111, 1, 4'b0000, 0, 0);
    end

    // Bounded wait for a grant on a late single request
    begin
      int cyc;
      cyc = 0;
      rst = 1'b0; req = 4'b1000; ack = 1'b0;
      do begin
        @(posedge clk); #1; cyc++;
      end while (!gnt_valid && cyc < 20);
      total++;
      if (!gnt_valid || gnt !== 4'b1000 || cyc != 1) begin
        bad++;
        $display("FAIL late_req: got gnt=%b after %0d cycles, want 1000 after 1", gnt, cyc);
      end
    end
    step("late_ack", 0, 4'b1000, 1, 4'b0000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter. Registers a one-hot grant vector that drives the downstream 4-to-2 encoder directly.
- The encoder maps an all-zero or multi-hot input to code 2'b11, so this block guarantees a strictly one-hot gnt whenever gnt_valid=1 and gnt=4'b0000 otherwise.
- Consumers qualify the encoded index with gnt_valid.
- Includes a hold-timeout watchdog so a stuck requester cannot starve the others.

Parameters:
- HOLD_MAX, 15: maximum cycles a grant is held without ack before forced release; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request lines, bit i = requester i, level-sensitive
- ack  input  1  single-cycle pulse from the consumer: current grant is finished
- gnt  output 4  registered one-hot grant; 4'b0000 when idle
- gnt_valid  output 1  high while in GRANT state
- timeout  output 1  single-cycle pulse on a forced release

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk/rst; all state is cleared on a rising clk edge with rst=1.
- Reset values: gnt=4'b0000, gnt_valid=0, timeout=0, state=IDLE, ptr=2'd0, hold_cnt=0.
- rst=1 mid-grant: the grant is dropped at that edge with no ack or timeout pulse.
- State machine has two states, IDLE and GRANT.
- IDLE, req==0: stay in IDLE; gnt=0.
- IDLE, req!=0:
  - Select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the next edge: gnt gets that one-hot bit, gnt_valid=1, hold_cnt=0, move to GRANT.
  - Latency from req sampled high to gnt visible is 1 cycle.
- GRANT, release conditions: leave GRANT when any of the following holds at an edge:
  - ack=1, or
  - the granted requester's req bit is 0, or
  - hold_cnt==HOLD_MAX-1.
- GRANT, on release at that edge:
  - gnt=0, gnt_valid=0, state=IDLE.
  - ptr = granted index + 1 (mod 4; index 3 wraps to 0).
- timeout=1 for exactly one cycle when the release was caused only by the hold limit, i.e. ack=0 and the granted req bit was still 1.
- If ack or the req drop coincides with the hold limit, timeout stays 0.
- GRANT with no release: hold_cnt increments by 1 per cycle; gnt is held stable.
- Changes on non-granted req bits have no effect while in GRANT.
- ack while in IDLE is ignored.
- Every release is followed by at least one IDLE cycle with gnt=0. This gap lets the downstream consumer see each grant as a distinct transaction.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,...
- Invariant: $onehot0(gnt) holds on every cycle, and gnt_valid == (gnt != 0).

Decomposition:
- Shared package rr_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - constant N_REQ = 4;
  - function idx_to_onehot(2-bit) -> 4-bit.
- One natural sub-module: rr_pick4. It is purely combinational: inputs req[3:0] and ptr[1:0], outputs sel_onehot[3:0] and sel_idx[1:0].
- The FSM, pointer and hold counter stay in rr_arbiter4.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then req=0 for 5 cycles -> gnt=0000, gnt_valid=0 and timeout=0 throughout.
- Single request: req=0100, ack pulsed 3 cycles after the grant -> gnt=0100 one cycle after req; released at the ack edge; ptr becomes 3.
- Round robin: req=1111 held, ack pulsed each time gnt_valid=1 -> grant order 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
- Wrap priority: after a grant to requester 3, req=1001 -> next grant is 0001, not 1000.
- Timeout: HOLD_MAX=4, req=0010 held, no ack -> gnt=0010 for exactly 4 cycles, then timeout pulse, then gnt=0000.
- Corner cases:
  - Granted req drops together with ack -> a single release with timeout=0.
  - rst asserted during GRANT -> gnt=0000 at the next edge; after rst deasserts, the next grant starts from ptr=0.
